// File: rtl/vga_pkg.sv
// Shared types and constants for VGA sync recovery.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: recovery FSM state enum, default 640x480 timing, count width.
package vga_pkg;

  // Width of the recovered column/row counts; covers totals up to 4096.
  localparam int CNT_W = 12;

  // Default 640x480 @ 60 Hz timing (pixel clock 25.175 MHz).
  localparam int DEF_TOTAL_COLS  = 800;
  localparam int DEF_TOTAL_ROWS  = 525;
  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_ACTIVE_ROWS = 480;
  localparam int DEF_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_e;

endpackage

// File: rtl/vga_pos_counter.sv
// Column/row position counter with synchronous load-to-zero and next-position prediction.
// Latency: counts update one cycle after load_zero_i/advance; prediction outputs are combinational.
// Backpressure: none; advances every clock unless loaded to zero.
//
// Ports:
//   clk_i, rst_n_i     clock, synchronous active-low reset
//   load_zero_i        load (0,0) on this edge instead of advancing
//   col_o, row_o       current position
//   next_col_o/row_o   position the counter will hold after a plain advance
//   h_expect_o         an HSync rise is due on the next sample (next col == 0)
//   v_expect_o         a VSync rise is due on the next sample (next pos == (0,0))
module vga_pos_counter
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS = DEF_TOTAL_ROWS
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_zero_i,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] row_o,
  output logic [CNT_W-1:0] next_col_o,
  output logic [CNT_W-1:0] next_row_o,
  output logic             h_expect_o,
  output logic             v_expect_o
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             col_wrap;

  // '>=' rather than '==' so an out-of-range value can never run away past the total.
  always_comb begin
    col_wrap = (col_q >= COL_LAST);
    col_d    = col_wrap ? '0 : col_q + CNT_W'(1);
    row_d    = row_q;
    if (col_wrap) begin
      row_d = (row_q >= ROW_LAST) ? '0 : row_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || load_zero_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign next_col_o = col_d;
  assign next_row_o = row_d;
  assign h_expect_o = (col_d == '0);
  assign v_expect_o = (col_d == '0) && (row_d == '0);

endmodule

// File: rtl/vga_sync_to_count.sv
// Rebuilds column/row counts from active-area sync flags and tracks lock to the configured geometry.
// Latency: 1 cycle from input flags to all outputs (counts, delayed syncs, pulses).
// Backpressure: none; one pixel per clock, outputs are free-running.
//
// Ports:
//   i_Clk, i_Rst_L        pixel clock, synchronous active-low reset
//   i_HSync, i_VSync      active-column / active-row flags from the sync generator
//   o_HSync, o_VSync      inputs delayed by one cycle
//   o_Col_Count/Row_Count recovered position, aligned with o_HSync/o_VSync
//   o_Frame_Start         pulse when the counts load (0,0) on a VSync rise
//   o_Locked              high while the geometry has been verified
//   o_Err                 pulse on a timing mismatch while acquiring or locked
module vga_sync_to_count
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_HSync,
  input  logic             i_VSync,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count,
  output logic             o_Frame_Start,
  output logic             o_Locked,
  output logic             o_Err
);

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_FRAMES);

  sync_state_e      state_q;
  logic [3:0]       good_q;
  logic [3:0]       good_inc;
  logic             hs_q, vs_q, frame_start_q, locked_q, err_q;
  logic             r_hs_q, r_vs_q;
  logic             hs_rise, vs_rise, hmis, vmis;
  logic             h_expect, v_expect, load_zero;
  logic [CNT_W-1:0] next_col, next_row;
  logic             unused_cfg;

  // Edge-detect history keeps sampling during reset, so releasing reset while the
  // source is mid-frame with VSync already high does not look like a frame start.
  always_ff @(posedge i_Clk) begin
    r_hs_q <= i_HSync;
    r_vs_q <= i_VSync;
  end

  assign hs_rise  = i_HSync & ~r_hs_q;
  assign vs_rise  = i_VSync & ~r_vs_q;
  assign hmis     = hs_rise ^ h_expect;
  assign vmis     = vs_rise ^ v_expect;
  assign good_inc = good_q + 4'd1;

  // Counts sit at zero while searching, realign on any VSync rise, and drop back
  // to zero when a line-timing error sends the FSM to SEARCH.
  assign load_zero = (state_q == SEARCH) | vs_rise | hmis;

  vga_pos_counter #(
    .TOTAL_COLS (TOTAL_COLS),
    .TOTAL_ROWS (TOTAL_ROWS)
  ) u_pos (
    .clk_i       (i_Clk),
    .rst_n_i     (i_Rst_L),
    .load_zero_i (load_zero),
    .col_o       (o_Col_Count),
    .row_o       (o_Row_Count),
    .next_col_o  (next_col),
    .next_row_o  (next_row),
    .h_expect_o  (h_expect),
    .v_expect_o  (v_expect)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q       <= SEARCH;
      good_q        <= '0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      hs_q          <= i_HSync;
      vs_q          <= i_VSync;
      frame_start_q <= vs_rise;
      err_q         <= 1'b0;
      case (state_q)
        SEARCH: begin
          // No checking here: the first VSync rise only establishes the phase.
          locked_q <= 1'b0;
          if (vs_rise) begin
            good_q  <= '0;
            state_q <= ACQUIRE;
          end
        end
        ACQUIRE: begin
          locked_q <= 1'b0;
          if (hmis) begin
            err_q   <= 1'b1;
            state_q <= SEARCH;
          end else if (vmis) begin
            err_q  <= 1'b1;
            good_q <= '0;
          end else if (vs_rise) begin
            good_q <= good_inc;
            if (good_inc == LOCK_TARGET) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (hmis) begin
            err_q    <= 1'b1;
            locked_q <= 1'b0;
            state_q  <= SEARCH;
          end else if (vmis) begin
            err_q    <= 1'b1;
            locked_q <= 1'b0;
            good_q   <= '0;
            state_q  <= ACQUIRE;
          end else begin
            locked_q <= 1'b1;
          end
        end
        default: begin
          locked_q <= 1'b0;
          state_q  <= SEARCH;
        end
      endcase
    end
  end

  assign o_HSync       = hs_q;
  assign o_VSync       = vs_q;
  assign o_Frame_Start = frame_start_q;
  assign o_Locked      = locked_q;
  assign o_Err         = err_q;

  // Active sizes describe the source but are not needed for recovery; the predicted
  // position is consumed only through h_expect/v_expect.
  assign unused_cfg = ^{next_col, next_row, CNT_W'(ACTIVE_COLS), CNT_W'(ACTIVE_ROWS)};

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Directed bench for vga_sync_to_count on a small 20x12 frame (16x8 active).
// Latency: expects every output one cycle behind the presented source position.
// Backpressure: none.
module tb_vga_sync_to_count;

  localparam int C  = 20;
  localparam int R  = 12;
  localparam int AC = 16;
  localparam int AR = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs_in, vs_in;
  logic        hs_out, vs_out;
  logic [11:0] col_cnt, row_cnt;
  logic        frame_start, locked, err;

  int tests = 0;
  int fails = 0;
  int gc = 0, gr = 0;      // source position to present next
  int pc = 0, pr = 0;      // position presented on the last edge
  logic phs = 1'b0, pvs = 1'b0;

  always #5 clk = ~clk;

  vga_sync_to_count #(
    .TOTAL_COLS  (C),
    .TOTAL_ROWS  (R),
    .ACTIVE_COLS (AC),
    .ACTIVE_ROWS (AR),
    .LOCK_FRAMES (2)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_HSync       (hs_in),
    .i_VSync       (vs_in),
    .o_HSync       (hs_out),
    .o_VSync       (vs_out),
    .o_Col_Count   (col_cnt),
    .o_Row_Count   (row_cnt),
    .o_Frame_Start (frame_start),
    .o_Locked      (locked),
    .o_Err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one source position (with optional forced-high flags), then advance the source.
  task automatic gen_cycle(input bit f_hs, input bit f_vs);
    hs_in = (gc < AC) | f_hs;
    vs_in = (gr < AR) | f_vs;
    phs = hs_in;
    pvs = vs_in;
    pc = gc;
    pr = gr;
    @(posedge clk);
    #1;
    if (gc == C - 1) begin
      gc = 0;
      gr = (gr == R - 1) ? 0 : gr + 1;
    end else begin
      gc++;
    end
  endtask

  // Normal source; outputs must equal the presented position one cycle later.
  task automatic track(input int n);
    for (int k = 0; k < n; k++) begin
      gen_cycle(1'b0, 1'b0);
      chk("trk_col", 32'(col_cnt), pc);
      chk("trk_row", 32'(row_cnt), pr);
      chk("trk_hs", 32'(hs_out), 32'(phs));
      chk("trk_vs", 32'(vs_out), 32'(pvs));
      chk("trk_fs", 32'(frame_start), 32'(pc == 0 && pr == 0));
      chk("trk_err", 32'(err), 0);
    end
  endtask

  // Normal source while the DUT is expected to be searching.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      gen_cycle(1'b0, 1'b0);
      chk("idle_col", 32'(col_cnt), 0);
      chk("idle_row", 32'(row_cnt), 0);
      chk("idle_lock", 32'(locked), 0);
      chk("idle_err", 32'(err), 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hs"}, 32'(hs_out), 0);
    chk({tag, "_vs"}, 32'(vs_out), 0);
    chk({tag, "_col"}, 32'(col_cnt), 0);
    chk({tag, "_row"}, 32'(row_cnt), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
    chk({tag, "_lock"}, 32'(locked), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    // 1. Reset held 10 cycles with toggling syncs.
    rst_n = 1'b0;
    hs_in = 1'b0;
    vs_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      hs_in = i[0];
      vs_in = i[1];
      @(posedge clk);
      #1;
    end
    chk_all_zero("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hs_in = i[0];
      vs_in = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_col", 32'(col_cnt), 0);
      chk("post_rst_row", 32'(row_cnt), 0);
      chk("post_rst_lock", 32'(locked), 0);
    end

    // 2. Acquire and lock from a source starting at (0,0).
    gc = 0;
    gr = 0;
    track(1);
    chk("acq_fs1", 32'(frame_start), 1);
    chk("acq_lock1", 32'(locked), 0);
    track(C * R);
    chk("acq_lock2", 32'(locked), 0);
    track(C * R - 1);
    chk("acq_lock_pre3", 32'(locked), 0);
    track(1);
    chk("acq_lock3", 32'(locked), 1);

    // 4. Missing HSync rise between rows 3 and 4 while locked.
    track(3 * C + 15);
    for (int i = 0; i < 4; i++) gen_cycle(1'b1, 1'b0);
    chk("mh_pre_col", 32'(col_cnt), 19);
    chk("mh_pre_row", 32'(row_cnt), 3);
    chk("mh_pre_lock", 32'(locked), 1);
    chk("mh_pre_err", 32'(err), 0);
    gen_cycle(1'b0, 1'b0);
    chk("mh_err", 32'(err), 1);
    chk("mh_lock", 32'(locked), 0);
    chk("mh_col", 32'(col_cnt), 0);
    chk("mh_row", 32'(row_cnt), 0);
    chk("mh_fs", 32'(frame_start), 0);
    idle(C - 1 + (R - 5) * C);
    track(1);
    track(C * R);
    chk("mh_relock2", 32'(locked), 0);
    track(C * R);
    chk("mh_relock3", 32'(locked), 1);

    // 5. Source restarts its frame 5 cycles early (HSync stays high, VSync rises).
    track((R - 1) * C + 14);
    chk("early_pre_lock", 32'(locked), 1);
    chk("early_pre_col", 32'(col_cnt), 14);
    gc = 0;
    gr = 0;
    gen_cycle(1'b0, 1'b0);
    chk("early_err", 32'(err), 1);
    chk("early_col", 32'(col_cnt), 0);
    chk("early_row", 32'(row_cnt), 0);
    chk("early_fs", 32'(frame_start), 1);
    chk("early_lock", 32'(locked), 0);
    track(C * R - 1);
    track(1);
    chk("early_relock1", 32'(locked), 0);
    track(C * R - 1);
    track(1);
    chk("early_relock2", 32'(locked), 1);

    // 6. One-cycle reset while locked at (11,6).
    track(6 * C + 11);
    chk("mr_pre_lock", 32'(locked), 1);
    rst_n = 1'b0;
    gen_cycle(1'b0, 1'b0);
    chk_all_zero("mr");
    rst_n = 1'b1;
    idle(5);

    // 3. Reset released with the source mid-frame at (7,5), VSync already high.
    rst_n = 1'b0;
    gc = 5;
    gr = 5;
    gen_cycle(1'b0, 1'b0);
    gen_cycle(1'b0, 1'b0);
    chk("mid_rst_col", 32'(col_cnt), 0);
    rst_n = 1'b1;
    idle((C - 7) + (R - 6) * C);
    track(1);
    chk("mid_fs", 32'(frame_start), 1);
    chk("mid_lock1", 32'(locked), 0);
    track(C * R);
    chk("mid_lock2", 32'(locked), 0);
    track(C * R);
    chk("mid_lock3", 32'(locked), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_sync_to_count.md
# vga_sync_to_count

Receive-side companion to the VGA sync generator: it takes the two active-area sync flags (high only inside the active columns and active rows) and rebuilds the column and row counters from them. Outputs are aligned one cycle behind the inputs. It also tracks whether the incoming sync geometry matches the configured frame and reports lock and errors. It sits downstream of the sync generator and upstream of any pattern, overlay or pixel-pipeline stage that needs pixel coordinates.

## Interface
Parameters:
- TOTAL_COLS, 800, columns per line including blanking (≤ 4096)
- TOTAL_ROWS, 525, rows per frame including blanking (≤ 4096)
- ACTIVE_COLS, 640, active columns
- ACTIVE_ROWS, 480, active rows
- LOCK_FRAMES, 2, consecutive correctly timed frame starts required to assert lock (1..15)

Ports:
- i_Clk  input  1  pixel clock; the single clock
- i_Rst_L  input  1  reset; **synchronous, active-low**
- i_HSync  input  1  high while the column is in the active area
- i_VSync  input  1  high while the row is in the active area
- o_HSync  output  1  i_HSync delayed by 1 cycle
- o_VSync  output  1  i_VSync delayed by 1 cycle
- o_Col_Count  output  12  recovered column, aligned to o_HSync/o_VSync
- o_Row_Count  output  12  recovered row, aligned to o_HSync/o_VSync
- o_Frame_Start  output  1  1-cycle pulse, high when the counts load to (0,0) on a VSync rise
- o_Locked  output  1  high while in LOCKED
- o_Err  output  1  1-cycle pulse on a timing mismatch while in ACQUIRE or LOCKED

## Operation
Edge detection and prediction:
- hs_rise = i_HSync & ~r_HSync; vs_rise = i_VSync & ~r_VSync, where r_* are the previous-cycle input samples.
- Predicted next position: col+1, wrapping to 0 at TOTAL_COLS-1. The row increments on a column wrap and wraps to 0 at TOTAL_ROWS-1.
- h_expect = (predicted col == 0); v_expect = (predicted col, row) == (0,0).
- Mismatch conditions:
  - hmis = hs_rise XOR h_expect
  - vmis = vs_rise XOR v_expect

State machine, states SEARCH, ACQUIRE, LOCKED:
- **SEARCH** (reset state):
  - Counts are held at 0.
  - On vs_rise: load (0,0), pulse o_Frame_Start, clear good_cnt, go to ACQUIRE.
- **ACQUIRE**:
  - Counts advance per the prediction. A vs_rise always loads (0,0) and pulses o_Frame_Start.
  - On hmis: pulse o_Err, load (0,0), go to SEARCH.
  - Else on vmis: pulse o_Err, clear good_cnt, stay in ACQUIRE. If vs_rise caused it, the counts realign to (0,0); otherwise they continue as predicted.
  - Else on a correct vs_rise: good_cnt+1. When it reaches LOCK_FRAMES, go to LOCKED.
- **LOCKED**:
  - On hmis: pulse o_Err, go to SEARCH.
  - On vmis: pulse o_Err, clear good_cnt, go to ACQUIRE, with the same realignment rule as ACQUIRE.
- hmis takes priority when hmis and vmis occur on the same edge.
- Reset (i_Rst_L=0 at an edge) wins over everything, including mid-frame and while LOCKED.
- All outputs reset to 0. The state resets to SEARCH and good_cnt to 0.

## Timing
- All outputs are registered.
- Latency is 1 cycle: on the edge where vs_rise is sampled, the outputs become o_HSync=1, o_VSync=1, counts (0,0), o_Frame_Start=1.
- o_Locked rises on the same edge as the o_Frame_Start that completes the LOCK_FRAMES count.
- o_Err is asserted for exactly one cycle, on the edge where the mismatch is sampled, coincident with the corrected counts.
- No checking is done in SEARCH, including on the SEARCH→ACQUIRE edge.
- Counters never exceed TOTAL-1. Wrap is modulo TOTAL_COLS/TOTAL_ROWS regardless of the inputs.

## Structure
- Shared package `vga_pkg`:
  - state enum (SEARCH, ACQUIRE, LOCKED)
  - default 640x480 timing constants
  - count width constant (12)
- One sub-module, `vga_pos_counter`:
  - col/row counter with synchronous load-to-zero
  - predicted-next outputs (next col, next row, h_expect, v_expect)
- The FSM, edge detection and error logic live in the top module.

## Test plan
1. **Reset.** Hold i_Rst_L=0 for 10 cycles while the syncs toggle → every output is 0; after release, counts stay at 0 until the first vs_rise.
2. **Acquire and lock.** Drive from an 800x525 sync generator starting at (0,0) → one cycle after the first VSync rise the outputs show (0,0) with o_Frame_Start=1. From then on, every cycle the counts equal the generator counts delayed by 1. o_Locked rises with the counts (0,0) of the third frame start (LOCK_FRAMES=2). o_Err never fires.
3. **Mid-frame start.** Release reset with the generator at col 300, row 200 → counts stay at 0 and o_Locked=0 until the generator reaches (0,0); then behaviour is as in scenario 2.
4. **Missing HSync pulse.** While LOCKED, hold i_HSync high across the boundary from row 100 to row 101 → o_Err pulses for one cycle, o_Locked drops to 0, and the counts return to 0 (SEARCH).
5. **Early frame start.** While LOCKED, force a VSync rise 5 cycles early → o_Err pulses for one cycle, the counts realign to (0,0) with o_Frame_Start=1, o_Locked drops, and lock is regained after two further correct frames.
6. **Reset mid-frame.** While LOCKED at col 417, row 250, assert i_Rst_L=0 for 1 cycle → on the next cycle all outputs are 0 and the state is SEARCH.
